// File: rtl/pkt_meta_decap.sv
// pkt_meta_decap: receive side of the metadata-prepend stream format.
// Strips the metadata beat that precedes each packet, latches its length and
// conf/DMA routing flags as sidebands, forwards head..tail with one cycle of
// latency, and checks the declared length against the counted length.
module pkt_meta_decap #(
  parameter int CHECK_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pkt_valid,
  input  logic [133:0]     i_pkt,
  output logic             o_pkt_valid,
  output logic [133:0]     o_pkt,
  output logic             o_meta_valid,
  output logic [11:0]      o_length,
  output logic             o_to_conf,
  output logic             o_to_dma,
  output logic             o_len_err,
  output logic             o_pkt_abort,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HEAD = 2'd1,
    IN_PKT    = 2'd2,
    DROP      = 2'd3
  } state_t;

  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_META = 2'b11;

  state_t           state_q;
  logic [7:0]       beat_cnt_q;
  logic             ovf_q;
  logic             pkt_valid_q;
  logic [133:0]     pkt_q;
  logic             meta_valid_q;
  logic [11:0]      length_q;
  logic             to_conf_q;
  logic             to_dma_q;
  logic             len_err_q;
  logic             abort_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic [1:0]       tag;
  logic [3:0]       vbytes;
  logic             len_mis;
  logic             err_evt;
  logic             pkt_evt;

  // Saturating increment: counters park at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  // Bytes seen so far: full 16-byte beats before the tail plus the tail's
  // valid bytes (field holds bytes-1). Wraps at 12 bits like the length field.
  function automatic logic [11:0] counted_len(input logic [7:0] bc,
                                              input logic [3:0] vb);
    return {bc, 4'b0000} + {8'b0, vb} + 12'd1;
  endfunction

  assign tag    = i_pkt[133:132];
  assign vbytes = i_pkt[131:128];

  // Event decode: which beats count as protocol errors, and packet completion.
  always_comb begin
    len_mis = (CHECK_LEN != 0) &&
              (ovf_q || (counted_len(beat_cnt_q, vbytes) != length_q));
    err_evt = 1'b0;
    pkt_evt = 1'b0;
    if (i_pkt_valid) begin
      case (state_q)
        IDLE:      err_evt = (tag != TAG_META);
        WAIT_HEAD: err_evt = (tag != TAG_HEAD);
        IN_PKT: begin
          err_evt = (tag == TAG_META) || (tag == TAG_HEAD) ||
                    ((tag == TAG_TAIL) && len_mis);
          pkt_evt = (tag == TAG_TAIL);
        end
        default:   err_evt = 1'b0;
      endcase
    end
    err_cnt_d = sat_inc(err_cnt_q, err_evt);
    pkt_cnt_d = sat_inc(pkt_cnt_q, pkt_evt);
  end

  // Decap FSM with registered forwarding path, sidebands and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 8'd0;
      ovf_q        <= 1'b0;
      pkt_valid_q  <= 1'b0;
      pkt_q        <= '0;
      meta_valid_q <= 1'b0;
      length_q     <= 12'd0;
      to_conf_q    <= 1'b0;
      to_dma_q     <= 1'b0;
      len_err_q    <= 1'b0;
      abort_q      <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      pkt_valid_q  <= 1'b0;
      meta_valid_q <= 1'b0;
      len_err_q    <= 1'b0;
      abort_q      <= 1'b0;
      err_cnt_q    <= err_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      if (i_pkt_valid) begin
        case (state_q)
          IDLE: begin
            if (tag == TAG_META) begin
              length_q  <= i_pkt[27:16];
              to_conf_q <= i_pkt[28];
              to_dma_q  <= i_pkt[29];
              state_q   <= WAIT_HEAD;
            end else if (tag == TAG_HEAD) begin
              state_q   <= DROP;
            end
          end
          WAIT_HEAD: begin
            case (tag)
              TAG_HEAD: begin
                pkt_valid_q  <= 1'b1;
                pkt_q        <= i_pkt;
                meta_valid_q <= 1'b1;
                beat_cnt_q   <= 8'd1;
                ovf_q        <= 1'b0;
                state_q      <= IN_PKT;
              end
              TAG_META: begin
                length_q  <= i_pkt[27:16];
                to_conf_q <= i_pkt[28];
                to_dma_q  <= i_pkt[29];
              end
              TAG_BODY: state_q <= DROP;
              default:  state_q <= IDLE;
            endcase
          end
          IN_PKT: begin
            case (tag)
              TAG_BODY: begin
                pkt_valid_q <= 1'b1;
                pkt_q       <= i_pkt;
                beat_cnt_q  <= beat_cnt_q + 8'd1;
                if (beat_cnt_q == 8'hFF)
                  ovf_q <= 1'b1;
              end
              TAG_TAIL: begin
                pkt_valid_q <= 1'b1;
                pkt_q       <= i_pkt;
                len_err_q   <= len_mis;
                state_q     <= IDLE;
              end
              TAG_META: begin
                abort_q   <= 1'b1;
                length_q  <= i_pkt[27:16];
                to_conf_q <= i_pkt[28];
                to_dma_q  <= i_pkt[29];
                state_q   <= WAIT_HEAD;
              end
              default: begin
                abort_q <= 1'b1;
                state_q <= DROP;
              end
            endcase
          end
          default: begin
            if (tag == TAG_TAIL) begin
              state_q <= IDLE;
            end else if (tag == TAG_META) begin
              length_q  <= i_pkt[27:16];
              to_conf_q <= i_pkt[28];
              to_dma_q  <= i_pkt[29];
              state_q   <= WAIT_HEAD;
            end
          end
        endcase
      end
    end
  end

  assign o_pkt_valid  = pkt_valid_q;
  assign o_pkt        = pkt_q;
  assign o_meta_valid = meta_valid_q;
  assign o_length     = length_q;
  assign o_to_conf    = to_conf_q;
  assign o_to_dma     = to_dma_q;
  assign o_len_err    = len_err_q;
  assign o_pkt_abort  = abort_q;
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pkt_meta_decap.sv
// Directed testbench for pkt_meta_decap.
module tb_pkt_meta_decap;

  logic         clk;
  logic         rst_n;
  logic         i_pkt_valid;
  logic [133:0] i_pkt;
  logic         o_pkt_valid;
  logic [133:0] o_pkt;
  logic         o_meta_valid;
  logic [11:0]  o_length;
  logic         o_to_conf;
  logic         o_to_dma;
  logic         o_len_err;
  logic         o_pkt_abort;
  logic [15:0]  o_pkt_cnt;
  logic [15:0]  o_err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_pkt  = 0;
  int exp_err  = 0;

  pkt_meta_decap #(.CHECK_LEN(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
    .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt), .o_meta_valid(o_meta_valid),
    .o_length(o_length), .o_to_conf(o_to_conf), .o_to_dma(o_to_dma),
    .o_len_err(o_len_err), .o_pkt_abort(o_pkt_abort),
    .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [133:0] mk_meta(input logic [11:0] len,
                                           input logic conf, input logic dma);
    logic [97:0] junk;
    junk = 98'h2_DEAD_BEEF_1234;
    return {2'b11, 4'h7, junk, dma, conf, len, 16'hFFFF};
  endfunction

  function automatic logic [133:0] mk_beat(input logic [1:0] tag,
                                           input logic [3:0] vb, input int seed);
    logic [31:0] w;
    w = 32'(seed) ^ 32'h5A5A_0000;
    return {tag, vb, w, ~w, w + 32'd3, w ^ 32'hFFFF};
  endfunction

  // Present one beat (or an idle cycle), then return 1 time unit past the edge.
  task automatic drive(input logic v, input logic [133:0] p);
    i_pkt_valid = v;
    i_pkt       = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_pkt_valid = 1'b0; i_pkt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({o_pkt_valid, o_meta_valid, o_len_err, o_pkt_abort, o_to_conf, o_to_dma} !== 6'b0) begin
      $display("FAIL reset_flags: got %b want 000000",
               {o_pkt_valid, o_meta_valid, o_len_err, o_pkt_abort, o_to_conf, o_to_dma});
    end else pass_cnt++;
    chk_cnt++;
    if ({o_pkt, o_length, o_pkt_cnt, o_err_cnt} !== '0) begin
      $display("FAIL reset_data: pkt=%h len=%0d pc=%0d ec=%0d want all 0",
               o_pkt, o_length, o_pkt_cnt, o_err_cnt);
    end else pass_cnt++;
    rst_n = 1'b1;
    drive(1'b0, '0);
  endtask

  // Good/mismatching 4-beat packet: meta, head, 2 body, tail vld 4'hb (60 bytes).
  task automatic test_good_packet(input logic [11:0] len, input string nm);
    logic [133:0] b;
    logic         exp_le;
    exp_le = (len != 12'd60);
    drive(1'b1, mk_meta(len, 1'b0, 1'b1));
    chk_cnt++;
    if (o_pkt_valid !== 1'b0 || o_length !== len || o_to_dma !== 1'b1 || o_to_conf !== 1'b0) begin
      $display("FAIL %s_meta: v=%b len=%0d dma=%b conf=%b want v=0 len=%0d dma=1 conf=0",
               nm, o_pkt_valid, o_length, o_to_dma, o_to_conf, len);
    end else pass_cnt++;
    b = mk_beat(2'b01, 4'hf, 1);
    drive(1'b1, b);
    chk_cnt++;
    if (o_pkt_valid !== 1'b1 || o_meta_valid !== 1'b1 || o_pkt !== b) begin
      $display("FAIL %s_head: v=%b mv=%b pkt=%h want v=1 mv=1 pkt=%h",
               nm, o_pkt_valid, o_meta_valid, o_pkt, b);
    end else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      b = mk_beat(2'b00, 4'hf, 10 + i);
      drive(1'b1, b);
      chk_cnt++;
      if (o_pkt_valid !== 1'b1 || o_meta_valid !== 1'b0 || o_pkt !== b) begin
        $display("FAIL %s_body%0d: v=%b mv=%b pkt=%h want v=1 mv=0 pkt=%h",
                 nm, i, o_pkt_valid, o_meta_valid, o_pkt, b);
      end else pass_cnt++;
    end
    b = mk_beat(2'b10, 4'hb, 20);
    drive(1'b1, b);
    exp_pkt++;
    if (exp_le) exp_err++;
    chk_cnt++;
    if (o_pkt_valid !== 1'b1 || o_pkt !== b || o_len_err !== exp_le) begin
      $display("FAIL %s_tail: v=%b le=%b want v=1 le=%b", nm, o_pkt_valid, o_len_err, exp_le);
    end else pass_cnt++;
    chk_cnt++;
    if (o_pkt_cnt !== 16'(exp_pkt) || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL %s_cnts: pc=%0d ec=%0d want pc=%0d ec=%0d",
               nm, o_pkt_cnt, o_err_cnt, exp_pkt, exp_err);
    end else pass_cnt++;
    drive(1'b0, '0);
    chk_cnt++;
    if ({o_pkt_valid, o_len_err, o_meta_valid} !== 3'b000 || o_length !== len) begin
      $display("FAIL %s_idle: v=%b le=%b mv=%b len=%0d want 0 0 0 len=%0d",
               nm, o_pkt_valid, o_len_err, o_meta_valid, o_length, len);
    end else pass_cnt++;
  endtask

  task automatic test_no_meta;
    int seen;
    seen = 0;
    drive(1'b1, mk_beat(2'b01, 4'hf, 30)); seen += int'(o_pkt_valid);
    drive(1'b1, mk_beat(2'b00, 4'hf, 31)); seen += int'(o_pkt_valid);
    drive(1'b1, mk_beat(2'b10, 4'h3, 32)); seen += int'(o_pkt_valid);
    exp_err++;
    chk_cnt++;
    if (seen != 0 || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL no_meta: forwarded=%0d ec=%0d want 0 ec=%0d", seen, o_err_cnt, exp_err);
    end else pass_cnt++;
    test_good_packet(12'd60, "after_drop");
  endtask

  task automatic test_abort;
    logic [133:0] b;
    drive(1'b1, mk_meta(12'd48, 1'b1, 1'b0));
    drive(1'b1, mk_beat(2'b01, 4'hf, 40));
    drive(1'b1, mk_beat(2'b00, 4'hf, 41));
    drive(1'b1, mk_meta(12'd32, 1'b0, 1'b0));
    exp_err++;
    chk_cnt++;
    if (o_pkt_abort !== 1'b1 || o_pkt_valid !== 1'b0 || o_length !== 12'd32 || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL abort_pulse: ab=%b v=%b len=%0d ec=%0d want ab=1 v=0 len=32 ec=%0d",
               o_pkt_abort, o_pkt_valid, o_length, o_err_cnt, exp_err);
    end else pass_cnt++;
    b = mk_beat(2'b01, 4'hf, 42);
    drive(1'b1, b);
    chk_cnt++;
    if (o_pkt_abort !== 1'b0 || o_pkt_valid !== 1'b1 || o_meta_valid !== 1'b1 || o_pkt !== b) begin
      $display("FAIL abort_head2: ab=%b v=%b mv=%b want ab=0 v=1 mv=1",
               o_pkt_abort, o_pkt_valid, o_meta_valid);
    end else pass_cnt++;
    drive(1'b1, mk_beat(2'b10, 4'hf, 43));
    exp_pkt++;
    chk_cnt++;
    if (o_len_err !== 1'b0 || o_pkt_valid !== 1'b1 || o_pkt_cnt !== 16'(exp_pkt) || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL abort_tail2: le=%b v=%b pc=%0d ec=%0d want le=0 v=1 pc=%0d ec=%0d",
               o_len_err, o_pkt_valid, o_pkt_cnt, o_err_cnt, exp_pkt, exp_err);
    end else pass_cnt++;
  endtask

  // Relatch in WAIT_HEAD (last meta wins) and an early tail back to IDLE.
  task automatic test_wait_head_errors;
    drive(1'b1, mk_meta(12'd100, 1'b0, 1'b0));
    drive(1'b1, mk_meta(12'd200, 1'b1, 1'b1));
    exp_err++;
    chk_cnt++;
    if (o_length !== 12'd200 || o_to_conf !== 1'b1 || o_to_dma !== 1'b1 || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL relatch: len=%0d conf=%b dma=%b ec=%0d want 200 1 1 ec=%0d",
               o_length, o_to_conf, o_to_dma, o_err_cnt, exp_err);
    end else pass_cnt++;
    drive(1'b1, mk_beat(2'b10, 4'h0, 50));
    exp_err++;
    chk_cnt++;
    if (o_pkt_valid !== 1'b0 || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL early_tail: v=%b ec=%0d want v=0 ec=%0d", o_pkt_valid, o_err_cnt, exp_err);
    end else pass_cnt++;
  endtask

  // Long packet: nbody body beats between head and a 16-byte tail.
  task automatic test_long(input logic [11:0] len, input int nbody,
                           input logic exp_le, input string nm);
    int fwd;
    fwd = 0;
    drive(1'b1, mk_meta(len, 1'b1, 1'b0));
    drive(1'b1, mk_beat(2'b01, 4'hf, 60)); fwd += int'(o_pkt_valid);
    for (int i = 0; i < nbody; i++) begin
      drive(1'b1, mk_beat(2'b00, 4'hf, 100 + i));
      fwd += int'(o_pkt_valid);
    end
    drive(1'b1, mk_beat(2'b10, 4'hf, 61)); fwd += int'(o_pkt_valid);
    exp_pkt++;
    if (exp_le) exp_err++;
    chk_cnt++;
    if (o_len_err !== exp_le || o_to_conf !== 1'b1 || fwd != nbody + 2) begin
      $display("FAIL %s: le=%b conf=%b fwd=%0d want le=%b conf=1 fwd=%0d",
               nm, o_len_err, o_to_conf, fwd, exp_le, nbody + 2);
    end else pass_cnt++;
    chk_cnt++;
    if (o_pkt_cnt !== 16'(exp_pkt) || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL %s_cnts: pc=%0d ec=%0d want pc=%0d ec=%0d",
               nm, o_pkt_cnt, o_err_cnt, exp_pkt, exp_err);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_packet;
    drive(1'b1, mk_meta(12'd60, 1'b1, 1'b1));
    drive(1'b1, mk_beat(2'b01, 4'hf, 70));
    drive(1'b0, '0);
    chk_cnt++;
    if (o_pkt_valid !== 1'b0 || o_pkt_cnt !== 16'(exp_pkt) || o_err_cnt !== 16'(exp_err)) begin
      $display("FAIL gap_hold: v=%b pc=%0d ec=%0d want v=0 pc=%0d ec=%0d",
               o_pkt_valid, o_pkt_cnt, o_err_cnt, exp_pkt, exp_err);
    end else pass_cnt++;
    drive(1'b1, mk_beat(2'b00, 4'hf, 71));
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_pkt_valid, o_meta_valid, o_len_err, o_pkt_abort, o_to_conf, o_to_dma} !== 6'b0 ||
        {o_pkt, o_length, o_pkt_cnt, o_err_cnt} !== '0) begin
      $display("FAIL async_reset: v=%b ab=%b len=%0d pc=%0d ec=%0d pkt=%h want all 0",
               o_pkt_valid, o_pkt_abort, o_length, o_pkt_cnt, o_err_cnt, o_pkt);
    end else pass_cnt++;
    i_pkt_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_pkt = 0;
    exp_err = 0;
    drive(1'b1, mk_meta(12'd60, 1'b0, 1'b1));
    chk_cnt++;
    if (o_pkt_abort !== 1'b0 || o_err_cnt !== 16'd0 || o_length !== 12'd60) begin
      $display("FAIL post_reset_meta: ab=%b ec=%0d len=%0d want ab=0 ec=0 len=60",
               o_pkt_abort, o_err_cnt, o_length);
    end else pass_cnt++;
    drive(1'b1, mk_beat(2'b01, 4'hf, 80));
    drive(1'b1, mk_beat(2'b00, 4'hf, 81));
    drive(1'b1, mk_beat(2'b00, 4'hf, 82));
    drive(1'b1, mk_beat(2'b10, 4'hb, 83));
    chk_cnt++;
    if (o_pkt_valid !== 1'b1 || o_len_err !== 1'b0 || o_pkt_cnt !== 16'd1 || o_err_cnt !== 16'd0) begin
      $display("FAIL post_reset_pkt: v=%b le=%b pc=%0d ec=%0d want v=1 le=0 pc=1 ec=0",
               o_pkt_valid, o_len_err, o_pkt_cnt, o_err_cnt);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_good_packet(12'd60, "good");
    test_good_packet(12'd64, "len_mismatch");
    test_no_meta;
    test_abort;
    test_wait_head_errors;
    test_long(12'd1024, 62, 1'b0, "long64");
    // 300 beats: counted length wraps to 704, so only the overflow flags it.
    test_long(12'd704, 298, 1'b1, "long300_ovf");
    test_reset_mid_packet;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
